mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
Memory-access stage controller for the 5-stage pipeline. It sits between the EX/MEM and MEM/WB pipeline registers and feeds the MEM/WB control register.
- Turns load/store intent into a valid/ready data-memory transaction: byte strobes, load extension, misalignment detection.
- Stalls the upstream pipeline while the memory is not ready.
- Hands RegWrite/ResultSrc/ReadData to MEM/WB, inserting a bubble while stalled.

Parameters:
XLEN, 32, datapath and address width (only 32 supported)
TIMEOUT_CYCLES, 255, BUSY-cycle limit before bus-error abort (used only with the optional feature)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
RegWriteM  in  1  register-write enable from EX/MEM
ResultSrcM  in  2  result select from EX/MEM (00 ALU, 01 memory, 10 PC+4, 11 reserved)
MemWriteM  in  1  store enable from EX/MEM
funct3M  in  3  access size/sign: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu
ALUResultM  in  32  effective address
WriteDataM  in  32  store data (unshifted, LSB-aligned)
mem_req  out  1  transaction request
mem_we  out  1  1 = store
mem_addr  out  32  word-aligned address ({ALUResultM[31:2],2'b00})
mem_wdata  out  32  lane-shifted store data
mem_wstrb  out  4  byte strobes (0 for loads)
mem_ready  in  1  memory accepts/completes the transaction this cycle
mem_rdata  in  32  read word; valid only when mem_ready=1
StallM  out  1  hold PC, IF/ID, ID/EX and EX/MEM
RegWriteOutM  out  1  to MEM/WB RegWriteM input
ResultSrcOutM  out  2  to MEM/WB ResultSrcM input
ReadDataM  out  32  extended load data to MEM/WB datapath register
MisalignM  out  1  misaligned access flagged
BusErrM  out  1  timeout abort pulse (tied 0 without the optional feature)

Behaviour:
- memop = MemWriteM | (ResultSrcM==2'b01).
- Misaligned when: half access with addr[0]=1, or word access with addr[1:0]!=0.
  - Misaligned op: no request, MisalignM=1, StallM=0, RegWriteOutM=0, no state change.
- FSM states: IDLE, BUSY.
  - IDLE, aligned memop: mem_req=1 combinationally.
    - mem_ready=1 the same cycle: transaction completes, stay IDLE.
    - Otherwise: go to BUSY.
  - BUSY: mem_req=1 held. Address, data and strobes stay stable because StallM holds EX/MEM.
    - mem_ready=1: complete, return to IDLE.
- StallM = mem_req & ~mem_ready. Deasserts in the completion cycle, so the next instruction enters on the following edge.
- RegWriteOutM = RegWriteM & ~StallM & ~MisalignM & ~BusErrM. It is 0 during every stalled cycle (bubble to MEM/WB).
- ResultSrcOutM = ResultSrcM, passed through unconditionally.
- Store strobes and data:
  - sb: strobe 1<<addr[1:0]; data byte replicated to all lanes.
  - sh: strobe 0011 or 1100; data halfword replicated.
  - sw: strobe 1111.
- Load data is selected from mem_rdata by addr[1:0]:
  - lb/lh sign-extend; lbu/lhu zero-extend.
  - ReadDataM is meaningful only in the completion cycle.
- Non-memop instruction: mem_req=0, StallM=0, outputs pass through, ReadDataM=0.
- Reset (any state, including mid-BUSY): state=IDLE, wait counter=0, BusErrM=0.
  - The request drops in the cycle after reset is sampled. Memory must tolerate the abandoned request.
- Reset values of combinational outputs follow from IDLE with whatever inputs are present; reset does not force them.

Optional Feature:
MEM_TIMEOUT_EN
- Defined:
  - 8-bit wait counter increments each BUSY cycle without mem_ready; it clears on entry to IDLE.
  - When the counter reaches TIMEOUT_CYCLES, the FSM returns to IDLE, mem_req drops and StallM drops.
  - BusErrM=1 for exactly that one cycle, and RegWriteOutM=0 that cycle.
- Undefined: no counter; BUSY waits indefinitely; BusErrM tied 0.

Decomposition:
- Shared pipeline package holds:
  - ResultSrc encodings (RES_ALU=2'b00, RES_MEM=2'b01, RES_PC4=2'b10).
  - funct3 size/sign constants.
  - FSM state encoding.
- One sub-module, lsu_lane_align: purely combinational strobe/store-shift/load-extend logic. The FSM and counter stay in the top module.

Test Plan:
- lw addr 0x100, mem_ready asserted on 4th request cycle, rdata 0xDEADBEEF -> StallM=1 for 3 cycles, RegWriteOutM=0 during them, completion cycle ReadDataM=0xDEADBEEF, RegWriteOutM=1.
- lb addr 0x103, rdata 0x80AABBCC, ready same cycle -> ReadDataM=0xFFFFFF80, StallM=0; lbu same -> 0x00000080.
- sh addr 0x102, WriteDataM=0x00001234 -> mem_wstrb=4'b1100, mem_wdata=0x12341234, mem_we=1, RegWriteOutM=0.
- lw addr 0x102 -> mem_req=0, MisalignM=1, StallM=0, RegWriteOutM=0.
- Reset asserted during BUSY (ready held 0) -> next cycle state IDLE, mem_req=0 if no memop is present; a following lw with immediate ready completes normally.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, ready never asserted -> BusErrM pulses once when the counter reaches 4, then StallM=0 and mem_req=0.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared pipeline definitions for the memory-access stage: result-select
// encodings, funct3 access size/sign codes, LSU FSM state encoding and a
// helper that decodes the access size from funct3.
package mem_access_unit_pkg;

    // ResultSrc encodings carried through EX/MEM and MEM/WB
    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    // funct3 load/store size and sign codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StBusy = 1'b1
    } lsu_state_e;

    typedef enum logic [1:0] {
        SzByte = 2'b00,
        SzHalf = 2'b01,
        SzWord = 2'b10
    } access_size_e;

    // funct3[2] only selects zero-extension; the low bits carry the size.
    function automatic access_size_e accessSize(input logic [2:0] funct3);
        access_size_e size;
        case (funct3[1:0])
            2'b00:   size = SzByte;
            2'b01:   size = SzHalf;
            default: size = SzWord;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/mem_access_unit_lsu_lane_align.sv
// Byte-lane alignment for the memory-access stage: store strobes, store data
// replication and load data selection with sign/zero extension. Purely
// combinational.
module lsu_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byteOff,
    input  logic        isStore,
    input  logic [31:0] storeData,
    input  logic [31:0] readWord,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] loadData
);

    access_size_e size;
    logic [7:0]   loadByte;
    logic [15:0]  loadHalf;
    logic         zeroExt;

    assign size    = accessSize(funct3);
    assign zeroExt = funct3[2];

    // Store side: replicate data across lanes so the strobe alone picks the target bytes.
    always_comb begin
        wstrb = 4'b0000;
        wdata = storeData;
        case (size)
            SzByte: begin
                wstrb = 4'b0001 << byteOff;
                wdata = {4{storeData[7:0]}};
            end
            SzHalf: begin
                wstrb = byteOff[1] ? 4'b1100 : 4'b0011;
                wdata = {2{storeData[15:0]}};
            end
            default: begin
                wstrb = 4'b1111;
                wdata = storeData;
            end
        endcase
        if (!isStore) begin
            wstrb = 4'b0000;
        end
    end

    // Load side: pick the addressed lane and extend to the full register width.
    always_comb begin
        loadByte = readWord[8*byteOff +: 8];
        loadHalf = byteOff[1] ? readWord[31:16] : readWord[15:0];
        case (size)
            SzByte:  loadData = zeroExt ? {24'h000000, loadByte}
                                        : {{24{loadByte[7]}}, loadByte};
            SzHalf:  loadData = zeroExt ? {16'h0000, loadHalf}
                                        : {{16{loadHalf[15]}}, loadHalf};
            default: loadData = readWord;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access stage controller: drives a valid/ready data-memory port from
// EX/MEM load/store intent, stalls the upstream pipeline while the memory is
// busy and feeds MEM/WB, inserting bubbles during stalls.
// Optional feature: define MEM_TIMEOUT_EN to abort a BUSY transaction after
// TIMEOUT_CYCLES waiting cycles with a one-cycle BusErrM pulse.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            RegWriteM,
    input  logic [1:0]      ResultSrcM,
    input  logic            MemWriteM,
    input  logic [2:0]      funct3M,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] WriteDataM,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wstrb,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            StallM,
    output logic            RegWriteOutM,
    output logic [1:0]      ResultSrcOutM,
    output logic [XLEN-1:0] ReadDataM,
    output logic            MisalignM,
    output logic            BusErrM
);

    lsu_state_e   stateQ, stateD;
    access_size_e size;
    logic         memop;
    logic         isLoad;
    logic         misaligned;
    logic         memReq;
    logic         timeoutHit;
    logic [3:0]   laneStrb;
    logic [31:0]  laneWdata;
    logic [31:0]  laneLoad;

    assign memop  = MemWriteM | (ResultSrcM == RES_MEM);
    assign isLoad = (ResultSrcM == RES_MEM) & ~MemWriteM;
    assign size   = accessSize(funct3M);

    // Alignment fault test on the effective address for the decoded size.
    always_comb begin
        case (size)
            SzByte:  misaligned = 1'b0;
            SzHalf:  misaligned = ALUResultM[0];
            default: misaligned = |ALUResultM[1:0];
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TimeoutLimit = 8'(TIMEOUT_CYCLES);

    logic [7:0] waitCntQ;

    assign timeoutHit = (stateQ == StBusy) && (waitCntQ == TimeoutLimit);

    // Wait counter: counts unanswered BUSY cycles, cleared whenever IDLE is next.
    always_ff @(posedge clk) begin
        if (reset) begin
            waitCntQ <= 8'd0;
        end else if (stateD == StIdle) begin
            waitCntQ <= 8'd0;
        end else if ((stateQ == StBusy) && !mem_ready) begin
            waitCntQ <= waitCntQ + 8'd1;
        end
    end
`else
    logic unusedTimeout;

    assign timeoutHit    = 1'b0;
    assign unusedTimeout = ^TIMEOUT_CYCLES;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ <= StIdle;
        end else begin
            stateQ <= stateD;
        end
    end

    // FSM next state and request generation.
    always_comb begin
        stateD = stateQ;
        memReq = 1'b0;
        case (stateQ)
            StIdle: begin
                if (memop && !misaligned) begin
                    memReq = 1'b1;
                    if (!mem_ready) begin
                        stateD = StBusy;
                    end
                end
            end
            StBusy: begin
                if (timeoutHit) begin
                    stateD = StIdle;
                end else begin
                    memReq = 1'b1;
                    if (mem_ready) begin
                        stateD = StIdle;
                    end
                end
            end
            default: stateD = StIdle;
        endcase
    end

    lsu_lane_align u_lane_align (
        .funct3    (funct3M),
        .byteOff   (ALUResultM[1:0]),
        .isStore   (MemWriteM),
        .storeData (WriteDataM),
        .readWord  (mem_rdata),
        .wstrb     (laneStrb),
        .wdata     (laneWdata),
        .loadData  (laneLoad)
    );

    // Memory port and MEM/WB hand-off; a stall or fault turns the write-back into a bubble.
    always_comb begin
        mem_req       = memReq;
        mem_we        = memReq & MemWriteM;
        mem_addr      = {ALUResultM[XLEN-1:2], 2'b00};
        mem_wdata     = laneWdata;
        mem_wstrb     = memReq ? laneStrb : 4'b0000;
        StallM        = memReq & ~mem_ready;
        MisalignM     = (stateQ == StIdle) & memop & misaligned;
        BusErrM       = timeoutHit;
        RegWriteOutM  = RegWriteM & ~StallM & ~MisalignM & ~BusErrM;
        ResultSrcOutM = ResultSrcM;
        ReadDataM     = (isLoad && !MisalignM) ? laneLoad : '0;
    end

endmodule
